ks_xor_stream: RTL and testbench

- Sits directly downstream of the ChaCha keystream generator (ksg).
- Accepts one 512-bit keystream block over a valid/ready handshake and splits it into sixteen 32-bit words.
- XORs each keystream word with one incoming plaintext/ciphertext word and emits the result as a 32-bit stream.
- Signals ksg (done) when the block is consumed, so ksg can release its output and compute the next block.

---
 rtl/ks_xor_stream_if.sv | 39 +++
 rtl/ks_xor_stream.sv | 124 ++++++++++++
 tb/tb_ks_xor_stream.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ks_xor_stream_if.sv
// Bundle of the keystream-block, plaintext and ciphertext handshakes of
// ks_xor_stream. The master side drives keystream blocks and plaintext words
// and accepts ciphertext; the slave side is the XOR stage itself.
interface ks_xor_stream_if #(
    parameter int WORD_W      = 32,
    parameter int BLOCK_WORDS = 16
);
    localparam int KEEP_W = WORD_W / 8;

    // Keystream block from ksg
    logic [WORD_W*BLOCK_WORDS-1:0] key_in;
    logic                          key_valid;
    logic                          key_ready;
    logic                          key_done;

    // Plaintext / ciphertext input stream
    logic [WORD_W-1:0]             pt_data;
    logic [KEEP_W-1:0]             pt_keep;
    logic                          pt_last;
    logic                          pt_valid;
    logic                          pt_ready;

    // XORed output stream
    logic [WORD_W-1:0]             ct_data;
    logic [KEEP_W-1:0]             ct_keep;
    logic                          ct_last;
    logic                          ct_valid;
    logic                          ct_ready;

    modport master (
        output key_in, key_valid, pt_data, pt_keep, pt_last, pt_valid, ct_ready,
        input  key_ready, key_done, pt_ready, ct_data, ct_keep, ct_last, ct_valid
    );

    modport slave (
        input  key_in, key_valid, pt_data, pt_keep, pt_last, pt_valid, ct_ready,
        output key_ready, key_done, pt_ready, ct_data, ct_keep, ct_last, ct_valid
    );
endinterface

// File: rtl/ks_xor_stream.sv
// Keystream XOR stage: holds one ChaCha keystream block, XORs it word by word
// onto the incoming message stream, and pulses key_done once the block is used
// up (all words consumed or message ended) so ksg can start the next block.
module ks_xor_stream #(
    parameter int WORD_W      = 32,
    parameter int BLOCK_WORDS = 16
) (
    input logic           clock,
    input logic           reset,
    ks_xor_stream_if.slave bus
);
    localparam int KEEP_W = WORD_W / 8;
    localparam int IDX_W  = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_WORDS - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  word_idx;
    logic [WORD_W-1:0] blk [BLOCK_WORDS];

    logic              key_ready;
    logic              pt_ready;
    logic              key_accept;
    logic              pt_accept;
    logic              block_end;
    logic [WORD_W-1:0] ct_next;

    logic [WORD_W-1:0] ct_data_q;
    logic [KEEP_W-1:0] ct_keep_q;
    logic              ct_last_q;
    logic              ct_valid_q;
    logic              key_done_q;

    assign key_accept = bus.key_valid && key_ready;
    assign pt_accept  = bus.pt_valid && pt_ready;
    // A block ends on its final keystream word or on the message's last word,
    // whichever comes first; both together still count as one block end.
    assign block_end  = pt_accept && ((word_idx == LAST_IDX) || bus.pt_last);

    // State register.
    // NOTE: sequential state is always assigned with <= so every flop samples
    // pre-edge values; blocking assignments here would create order races.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic: load a block in IDLE, stream until the block ends.
    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (key_accept) state_next = STREAM;
            STREAM:  if (block_end)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs: ready for a block only in IDLE, ready for a word only
    // in STREAM when the single output register is empty or draining.
    always_comb begin
        key_ready = (state == IDLE);
        pt_ready  = (state == STREAM) && (!ct_valid_q || bus.ct_ready);
    end

    // Keystream block register and word pointer.
    // NOTE: the block register is cleared on reset so a discarded block can
    // never leak into later output; it is small enough to live in flops.
    always_ff @(posedge clock) begin
        if (reset) begin
            word_idx <= '0;
            for (int i = 0; i < BLOCK_WORDS; i++) blk[i] <= '0;
        end else if (key_accept) begin
            word_idx <= '0;
            for (int i = 0; i < BLOCK_WORDS; i++) blk[i] <= bus.key_in[WORD_W*i +: WORD_W];
        end else if (pt_accept) begin
            word_idx <= block_end ? '0 : word_idx + 1'b1;
        end
    end

    // XOR the current keystream word onto the input word, zeroing disabled bytes.
    always_comb begin
        ct_next = bus.pt_data ^ blk[word_idx];
        for (int b = 0; b < KEEP_W; b++) begin
            if (!bus.pt_keep[b]) ct_next[8*b +: 8] = '0;
        end
    end

    // Output register (load on accept, release on downstream accept) and the
    // one-cycle block-consumed pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            ct_data_q  <= '0;
            ct_keep_q  <= '0;
            ct_last_q  <= 1'b0;
            ct_valid_q <= 1'b0;
            key_done_q <= 1'b0;
        end else begin
            key_done_q <= block_end;
            if (pt_accept) begin
                ct_data_q  <= ct_next;
                ct_keep_q  <= bus.pt_keep;
                ct_last_q  <= bus.pt_last;
                ct_valid_q <= 1'b1;
            end else if (bus.ct_ready) begin
                ct_valid_q <= 1'b0;
            end
        end
    end

    assign bus.key_ready = key_ready;
    assign bus.key_done  = key_done_q;
    assign bus.pt_ready  = pt_ready;
    assign bus.ct_data   = ct_data_q;
    assign bus.ct_keep   = ct_keep_q;
    assign bus.ct_last   = ct_last_q;
    assign bus.ct_valid  = ct_valid_q;
endmodule

// File: tb/tb_ks_xor_stream.sv
// Self-checking bench for ks_xor_stream: directed scenarios (reset, full block,
// backpressure, partial block, mid-block reset, back-to-back blocks) followed
// by randomized messages, all checked against a word-level reference model.
module tb_ks_xor_stream;
    localparam int WORD_W      = 32;
    localparam int BLOCK_WORDS = 16;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    ks_xor_stream_if #(.WORD_W(WORD_W), .BLOCK_WORDS(BLOCK_WORDS)) bus ();

    ks_xor_stream #(.WORD_W(WORD_W), .BLOCK_WORDS(BLOCK_WORDS)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: the block being consumed and the position in it.
    logic [31:0] stim_key [BLOCK_WORDS];
    logic [31:0] m_key    [BLOCK_WORDS];
    int          m_idx     = 0;
    int          exp_done  = 0;
    logic [36:0] exp_q [$];

    // Observed ciphertext words and key_done pulses.
    logic [36:0] got_q [$];
    int          done_cnt  = 0;
    int          cmp_ptr   = 0;
    bit          rand_bp   = 1'b0;

    // Record every accepted output word and every key_done pulse.
    always @(posedge clock) begin
        if (!reset && bus.ct_valid && bus.ct_ready)
            got_q.push_back({bus.ct_last, bus.ct_keep, bus.ct_data});
        if (!reset && bus.key_done) done_cnt++;
    end

    // Global time limit so the run always terminates.
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mask_bytes(input logic [31:0] d, input logic [3:0] k);
        logic [31:0] r;
        r = d;
        for (int b = 0; b < 4; b++) if (!k[b]) r[8*b +: 8] = 8'h00;
        return r;
    endfunction

    // Model one accepted word: XOR with the next unused keystream word; the
    // block is finished after its sixteenth word or a last word.
    task automatic model_push(input logic [31:0] d, input logic [3:0] k, input logic l);
        exp_q.push_back({l, k, mask_bytes(d ^ m_key[m_idx], k)});
        m_idx++;
        if (l || m_idx == BLOCK_WORDS) begin
            m_idx = 0;
            exp_done++;
        end
    endtask

    task automatic pack_key();
        for (int i = 0; i < BLOCK_WORDS; i++) bus.key_in[32*i +: 32] = stim_key[i];
    endtask

    task automatic do_reset(input int n);
        reset         = 1'b1;
        bus.key_valid = 1'b0;
        bus.pt_valid  = 1'b0;
        repeat (n) @(negedge clock);
        reset = 1'b0;
        m_idx = 0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_ct_valid"},  bus.ct_valid,  0);
        check({tag, "_ct_data"},   bus.ct_data,   0);
        check({tag, "_key_done"},  bus.key_done,  0);
        check({tag, "_key_ready"}, bus.key_ready, 1);
        check({tag, "_pt_ready"},  bus.pt_ready,  0);
    endtask

    // Offer stim_key and wait (bounded) for the block handshake.
    task automatic send_key(input bit hold);
        pack_key();
        bus.key_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            #1;
            if (bus.key_ready) break;
            @(negedge clock);
        end
        check("key_handshake", bus.key_ready, 1);
        m_key = stim_key;
        m_idx = 0;
        @(negedge clock);
        if (!hold) bus.key_valid = 1'b0;
    endtask

    // One word that must be accepted at the next edge (ct_ready held high).
    task automatic word_cycle(input logic [31:0] d, input logic [3:0] k, input logic l);
        bus.pt_data  = d;
        bus.pt_keep  = k;
        bus.pt_last  = l;
        bus.pt_valid = 1'b1;
        #1;
        check("pt_ready_direct", bus.pt_ready, 1);
        model_push(d, k, l);
        @(negedge clock);
    endtask

    // One word offered under optional random backpressure, bounded wait.
    task automatic put_word(input logic [31:0] d, input logic [3:0] k, input logic l);
        bus.pt_data  = d;
        bus.pt_keep  = k;
        bus.pt_last  = l;
        bus.pt_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            if (rand_bp) bus.ct_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.pt_ready) break;
            @(negedge clock);
        end
        check("pt_ready_wait", bus.pt_ready, 1);
        model_push(d, k, l);
        @(negedge clock);
        bus.pt_valid = 1'b0;
    endtask

    task automatic drain();
        bus.pt_valid = 1'b0;
        bus.ct_ready = 1'b1;
        repeat (3) @(negedge clock);
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = cmp_ptr; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, "_word"}, got_q[i], exp_q[i]);
        cmp_ptr = (got_q.size() > exp_q.size()) ? got_q.size() : exp_q.size();
        check({tag, "_key_done_count"}, done_cnt, exp_done);
    endtask

    initial begin
        logic [31:0] d;
        int          n;
        int          saved_done;

        bus.key_in    = '0;
        bus.key_valid = 1'b0;
        bus.pt_data   = '0;
        bus.pt_keep   = '0;
        bus.pt_last   = 1'b0;
        bus.pt_valid  = 1'b0;
        bus.ct_ready  = 1'b1;

        // Reset state
        do_reset(2);
        reset_checks("reset");

        // Full block: key word i = A5A5_000i, zero plaintext
        for (int i = 0; i < BLOCK_WORDS; i++) stim_key[i] = {16'hA5A5, 16'(i)};
        send_key(1'b0);
        for (int i = 0; i < BLOCK_WORDS; i++) begin
            word_cycle(32'h0, 4'hF, 1'b0);
            check("full_ct_data", bus.ct_data, {16'hA5A5, 16'(i)});
            check("full_key_done", bus.key_done, (i == BLOCK_WORDS - 1));
        end
        check("full_key_ready_on_done", bus.key_ready, 1);
        bus.pt_valid = 1'b0;
        @(negedge clock);
        check("full_done_single", bus.key_done, 0);
        drain();
        compare_stream("full");

        // Backpressure after word 4 for three cycles
        send_key(1'b0);
        for (int i = 0; i < 5; i++) word_cycle(32'hFFFF_FFFF, 4'hF, 1'b0);
        bus.ct_ready = 1'b0;
        bus.pt_data  = 32'hFFFF_FFFF;
        bus.pt_valid = 1'b1;
        repeat (3) begin
            #1;
            check("bp_hold_data", bus.ct_data, 32'h5A5A_FFFB);
            check("bp_hold_valid", bus.ct_valid, 1);
            check("bp_pt_ready", bus.pt_ready, 0);
            @(negedge clock);
        end
        bus.ct_ready = 1'b1;
        word_cycle(32'hFFFF_FFFF, 4'hF, 1'b0);
        check("bp_resume_data", bus.ct_data, 32'h5A5A_FFFA);
        for (int i = 6; i < BLOCK_WORDS; i++) word_cycle(32'hFFFF_FFFF, 4'hF, 1'b0);
        drain();
        compare_stream("bp");

        // Partial block ending on word 5 with a byte mask
        for (int i = 0; i < BLOCK_WORDS; i++) stim_key[i] = $urandom;
        stim_key[5] = 32'h0000_280B;
        send_key(1'b0);
        for (int i = 0; i < 5; i++) word_cycle($urandom, 4'hF, 1'b0);
        word_cycle(32'h1234_5678, 4'b0011, 1'b1);
        check("partial_ct_data", bus.ct_data, 32'h0000_7E73);
        check("partial_ct_last", bus.ct_last, 1);
        check("partial_ct_keep", bus.ct_keep, 4'b0011);
        check("partial_key_done", bus.key_done, 1);
        bus.pt_valid = 1'b0;
        @(negedge clock);
        check("partial_done_single", bus.key_done, 0);
        for (int i = 0; i < BLOCK_WORDS; i++) stim_key[i] = $urandom;
        send_key(1'b0);
        d = $urandom;
        word_cycle(d, 4'hF, 1'b1);
        check("partial_next_word0", bus.ct_data, d ^ stim_key[0]);
        drain();
        compare_stream("partial");

        // Reset in the middle of a block after 7 words
        for (int i = 0; i < BLOCK_WORDS; i++) stim_key[i] = $urandom;
        send_key(1'b0);
        for (int i = 0; i < 7; i++) word_cycle($urandom, 4'hF, 1'b0);
        drain();
        compare_stream("pre_reset");
        saved_done = done_cnt;
        do_reset(2);
        reset_checks("midreset");
        check("midreset_no_done", done_cnt, saved_done);
        for (int i = 0; i < BLOCK_WORDS; i++) stim_key[i] = $urandom;
        send_key(1'b0);
        d = $urandom;
        word_cycle(d, 4'hF, 1'b1);
        check("midreset_next_word0", bus.ct_data, d ^ stim_key[0]);
        drain();
        compare_stream("midreset");

        // Back-to-back blocks with key_valid held high
        for (int i = 0; i < BLOCK_WORDS; i++) stim_key[i] = {16'hA5A5, 16'(i)};
        send_key(1'b1);
        for (int i = 0; i < BLOCK_WORDS; i++) stim_key[i] = 32'hDEAD_BEEF;
        pack_key();
        for (int i = 0; i < BLOCK_WORDS; i++) word_cycle(32'h0, 4'hF, 1'b0);
        check("b2b_key_done", bus.key_done, 1);
        check("b2b_key_ready", bus.key_ready, 1);
        #1;
        check("b2b_idle_pt_ready", bus.pt_ready, 0);
        m_key = stim_key;
        m_idx = 0;
        @(negedge clock);
        bus.key_valid = 1'b0;
        word_cycle(32'h0, 4'hF, 1'b0);
        check("b2b_first_data", bus.ct_data, 32'hDEAD_BEEF);
        check("b2b_first_valid", bus.ct_valid, 1);
        for (int i = 1; i < BLOCK_WORDS - 1; i++) word_cycle(32'h0, 4'hF, 1'b0);
        word_cycle(32'h0, 4'hF, 1'b1);
        drain();
        compare_stream("b2b");

        // Randomized messages with random keep, last and backpressure
        rand_bp = 1'b1;
        for (int m = 0; m < 10; m++) begin
            for (int i = 0; i < BLOCK_WORDS; i++) stim_key[i] = $urandom;
            send_key(1'b0);
            n = $urandom_range(1, BLOCK_WORDS);
            for (int i = 0; i < n; i++)
                put_word($urandom, 4'($urandom),
                         (i == n - 1) && ((n < BLOCK_WORDS) || ($urandom_range(0, 1) == 1)));
            drain();
            check("rand_key_ready", bus.key_ready, 1);
        end
        rand_bp = 1'b0;
        compare_stream("random");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
